// File: rtl/aq_gemac_rx_reader_if.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | aq_gemac_rx_reader_if                                                   |
// | MAC RX buffer read side, framed word output and statistics bundle.      |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
interface aq_gemac_rx_reader_if;
  logic        rx_buff_re;
  logic [31:0] rx_buff_data;
  logic        rx_buff_empty;
  logic        rx_buff_valid;
  logic [15:0] rx_buff_length;
  logic [31:0] rx_buff_status;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sop;
  logic        out_eop;
  logic [3:0]  out_be;
  logic [15:0] out_length;
  logic [31:0] out_status;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;

  modport master (
    output rx_buff_re, out_valid, out_data, out_sop, out_eop, out_be,
           out_length, out_status, frame_cnt, drop_cnt,
    input  rx_buff_data, rx_buff_empty, rx_buff_valid, rx_buff_length,
           rx_buff_status, out_ready
  );

  modport slave (
    input  rx_buff_re, out_valid, out_data, out_sop, out_eop, out_be,
           out_length, out_status, frame_cnt, drop_cnt,
    output rx_buff_data, rx_buff_empty, rx_buff_valid, rx_buff_length,
           rx_buff_status, out_ready
  );
endinterface
`default_nettype wire

// File: rtl/aq_gemac_rx_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | aq_gemac_rx_reader                                                      |
// | Pops frames from the MAC RX buffer into a 2-deep skid buffer, drops     |
// | filtered frames. Optional statistics: AQ_GEMAC_RX_READER_STATS_EN.      |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module aq_gemac_rx_reader #(
  parameter logic [31:0] DROP_MASK = 32'h0000_0000,
  parameter logic [15:0] MAX_LEN   = 16'd1522
) (
  input wire clk,
  input wire rst,
  aq_gemac_rx_reader_if.master bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_READ  = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;
  localparam logic [1:0] c_GAP   = 2'd3;

  logic [1:0]       r_state;
  logic             r_gap;
  logic [15:0]      r_pop_left;
  logic [15:0]      r_cap_left;
  logic             r_cap_first;
  logic             r_pend;
  logic [3:0]       r_be_last;
  logic [15:0]      r_len;
  logic [31:0]      r_status;
  logic [1:0][31:0] r_data;
  logic [1:0]       r_sop;
  logic [1:0]       r_eop;
  logic [1:0][3:0]  r_be;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  logic [15:0] w_words;
  logic        w_drop;
  logic [3:0]  w_be_last;
  logic        w_accept;
  logic        w_xfer;
  logic [2:0]  w_level;
  logic        w_room;
  logic        w_re;
  logic        w_cap_last;

  assign w_words = (bus.rx_buff_length == 16'd0) ? 16'd1 :
                   ({2'b00, bus.rx_buff_length[15:2]} + {15'd0, |bus.rx_buff_length[1:0]});
  assign w_drop  = (bus.rx_buff_length == 16'd0) || (bus.rx_buff_length > MAX_LEN) ||
                   ((bus.rx_buff_status & DROP_MASK) != 32'd0);

  always_comb begin
    w_be_last = 4'b1111;
    case (bus.rx_buff_length[1:0])
      2'b01:   w_be_last = 4'b0001;
      2'b10:   w_be_last = 4'b0011;
      2'b11:   w_be_last = 4'b0111;
      default: w_be_last = 4'b1111;
    endcase
  end

  // A new frame is only taken once the previous EOP has left the skid buffer.
  assign w_accept   = (r_state == c_IDLE) && bus.rx_buff_valid && (r_count == 2'd0) && !r_pend;
  assign w_xfer     = (r_count != 2'd0) && bus.out_ready;
  // Occupancy once the in-flight word lands, net of this cycle's transfer.
  assign w_level    = {1'b0, r_count} + {2'b00, r_pend} - {2'b00, w_xfer};
  assign w_room     = (w_level < 3'd2);
  assign w_re       = !bus.rx_buff_empty && (r_pop_left != 16'd0) &&
                      (((r_state == c_READ) && w_room) || (r_state == c_DRAIN));
  assign w_cap_last = (r_cap_left == 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_IDLE;
      r_gap       <= 1'b0;
      r_pop_left  <= 16'd0;
      r_cap_left  <= 16'd0;
      r_cap_first <= 1'b0;
      r_pend      <= 1'b0;
      r_be_last   <= 4'd0;
      r_len       <= 16'd0;
      r_status    <= 32'd0;
    end else begin
      r_pend <= w_re && (r_state == c_READ);
      if (r_pend) begin
        r_cap_left  <= r_cap_left - 16'd1;
        r_cap_first <= 1'b0;
      end
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_len       <= bus.rx_buff_length;
            r_status    <= bus.rx_buff_status;
            r_be_last   <= w_be_last;
            r_pop_left  <= w_words;
            r_cap_left  <= w_words;
            r_cap_first <= 1'b1;
            r_state     <= w_drop ? c_DRAIN : c_READ;
          end
        end
        c_READ, c_DRAIN: begin
          if (w_re) begin
            r_pop_left <= r_pop_left - 16'd1;
            if (r_pop_left == 16'd1) begin
              r_state <= c_GAP;
              r_gap   <= 1'b0;
            end
          end
        end
        c_GAP: begin
          if (r_gap) r_state <= c_IDLE;
          else       r_gap   <= 1'b1;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data   <= '0;
      r_sop    <= '0;
      r_eop    <= '0;
      r_be     <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (r_pend) begin
        r_data[r_wr_ptr] <= bus.rx_buff_data;
        r_sop[r_wr_ptr]  <= r_cap_first;
        r_eop[r_wr_ptr]  <= w_cap_last;
        r_be[r_wr_ptr]   <= w_cap_last ? r_be_last : 4'b1111;
        r_wr_ptr         <= ~r_wr_ptr;
      end
      if (w_xfer) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, r_pend} - {1'b0, w_xfer};
    end
  end

  assign bus.rx_buff_re = w_re;
  assign bus.out_valid  = (r_count != 2'd0);
  assign bus.out_data   = r_data[r_rd_ptr];
  assign bus.out_sop    = bus.out_valid && r_sop[r_rd_ptr];
  assign bus.out_eop    = bus.out_valid && r_eop[r_rd_ptr];
  assign bus.out_be     = bus.out_valid ? r_be[r_rd_ptr] : 4'd0;
  assign bus.out_length = r_len;
  assign bus.out_status = r_status;

`ifdef AQ_GEMAC_RX_READER_STATS_EN
  logic [15:0] r_frame_cnt;
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_cnt <= 16'd0;
      r_drop_cnt  <= 16'd0;
    end else begin
      if (w_xfer && r_eop[r_rd_ptr] && (r_frame_cnt != 16'hFFFF))
        r_frame_cnt <= r_frame_cnt + 16'd1;
      if (w_accept && w_drop && (r_drop_cnt != 16'hFFFF))
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign bus.frame_cnt = r_frame_cnt;
  assign bus.drop_cnt  = r_drop_cnt;
`else
  assign bus.frame_cnt = 16'd0;
  assign bus.drop_cnt  = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_aq_gemac_rx_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_aq_gemac_rx_reader                                                   |
// | Scoreboard bench: directed frames against an RX buffer model.           |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module tb_aq_gemac_rx_reader;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [3:0]  be;
    logic [15:0] len;
    logic [31:0] status;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aq_gemac_rx_reader_if bus ();

  aq_gemac_rx_reader #(
    .DROP_MASK(32'h0000_0001),
    .MAX_LEN  (16'd1522)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int exp_frames = 0;
  int exp_drops = 0;
  int fid = 0;
  exp_t exp_q[$];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // RX buffer model: word appears on rx_buff_data the cycle after RE.
  logic [31:0] rx_mem [0:1023];
  int   wr_ptr = 0;
  int   rd_ptr = 0;
  int   pop_total = 0;
  logic force_empty = 1'b0;
  assign bus.rx_buff_empty = force_empty || (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (!rst && bus.rx_buff_re) begin
      bus.rx_buff_data <= rx_mem[rd_ptr % 1024];
      rd_ptr           <= rd_ptr + 1;
      pop_total        <= pop_total + 1;
    end
  end

  // Monitor: owns out_ready, compares every transfer and every held word.
  int          xfer_idx = 0;
  int          stall_seq = 0;
  int          stall_seen = 0;
  int          stall_cnt = 0;
  logic [38:0] held;
  bit          held_v = 0;

  initial begin
    exp_t e;
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst && stall_seq != stall_seen && xfer_idx == 3) begin
        stall_cnt  = 5;
        stall_seen = stall_seq;
      end
      if (stall_cnt > 0) begin
        bus.out_ready = 1'b0;
        stall_cnt--;
      end else begin
        bus.out_ready = 1'b1;
      end
      #1;
      if (rst) begin
        exp_q.delete();
        xfer_idx = 0;
        held_v   = 0;
      end else begin
        if (held_v) begin
          chk("hold_stable", {bus.out_valid, bus.out_data, bus.out_sop, bus.out_eop, bus.out_be}, held);
          held_v = 0;
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_word: actual=%0h required=no output", bus.out_data);
          end else begin
            e = exp_q.pop_front();
            chk("word", {bus.out_data, bus.out_sop, bus.out_eop, bus.out_be, bus.out_length},
                        {e.data, e.sop, e.eop, e.be, e.len});
            if (e.sop) chk("status", bus.out_status, e.status);
          end
          xfer_idx = bus.out_eop ? 0 : xfer_idx + 1;
        end else if (bus.out_valid) begin
          held   = {bus.out_valid, bus.out_data, bus.out_sop, bus.out_eop, bus.out_be};
          held_v = 1;
        end
      end
    end
  end

  task automatic load_frame(input int len, input logic [31:0] st, input bit drop, output int words);
    exp_t       e;
    logic [3:0] be_last;
    words = (len == 0) ? 1 : (len + 3) / 4;
    case (len % 4)
      0:       be_last = 4'b1111;
      1:       be_last = 4'b0001;
      2:       be_last = 4'b0011;
      default: be_last = 4'b0111;
    endcase
    fid++;
    for (int i = 0; i < words; i++) begin
      rx_mem[(wr_ptr + i) % 1024] = {fid[7:0], 8'hA5, i[15:0]};
      if (!drop) begin
        e.data   = {fid[7:0], 8'hA5, i[15:0]};
        e.sop    = (i == 0);
        e.eop    = (i == words - 1);
        e.be     = e.eop ? be_last : 4'b1111;
        e.len    = len[15:0];
        e.status = st;
        exp_q.push_back(e);
      end
    end
    wr_ptr = wr_ptr + words;
  endtask

  task automatic send_frame(input int len, input logic [31:0] st, input bit lat,
                            input int empty_at, input bit stall);
    int words, p0, e_left;
    bit drop, done, e_done, e_rel;
    drop = (len == 0) || (len > 1522) || ((st & 32'h1) != 0);
    load_frame(len, st, drop, words);
    if (stall) stall_seq++;
    p0 = pop_total;
    done = 0; e_done = 0; e_rel = 0; e_left = 0;
    @(negedge clk);
    bus.rx_buff_valid  = 1'b1;
    bus.rx_buff_length = len[15:0];
    bus.rx_buff_status = st;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      #2;
      if (lat && cyc == 1) chk("latency_re", bus.rx_buff_re, 1);
      if (lat && cyc == 3) chk("latency_sop", {bus.out_valid, bus.out_sop}, 2'b11);
      if (pop_total != p0) bus.rx_buff_valid = 1'b0;
      if (e_rel) begin
        force_empty = 1'b0;
        e_rel = 0;
      end
      if (empty_at > 0 && !e_done && (pop_total - p0) == empty_at) begin
        force_empty = 1'b1;
        e_left = 3;
        e_done = 1;
      end
      if (e_left > 0) begin
        #1;
        chk("re_while_empty", bus.rx_buff_re, 0);
        e_left--;
        if (e_left == 0) e_rel = 1;
      end
      if ((pop_total - p0) >= words && exp_q.size() == 0 && !force_empty && e_left == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL frame_timeout: len=%0d pops=%0d required=%0d", len, pop_total - p0, words);
      force_empty = 1'b0;
      bus.rx_buff_valid = 1'b0;
    end
    repeat (4) @(negedge clk);
    chk("pop_count", pop_total - p0, words);
    if (drop) exp_drops++;
    else      exp_frames++;
  endtask

  task automatic check_stats();
    int fc, dc;
`ifdef AQ_GEMAC_RX_READER_STATS_EN
    fc = exp_frames;
    dc = exp_drops;
`else
    fc = 0;
    dc = 0;
`endif
    chk("frame_cnt", bus.frame_cnt, fc);
    chk("drop_cnt", bus.drop_cnt, dc);
  endtask

  task automatic reset_mid();
    int  words;
    bit  hit;
    hit = 0;
    load_frame(64, 32'h0, 1'b0, words);
    @(negedge clk);
    bus.rx_buff_valid  = 1'b1;
    bus.rx_buff_length = 16'd64;
    bus.rx_buff_status = 32'h0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      #2;
      if (rd_ptr != wr_ptr - words) bus.rx_buff_valid = 1'b0;
      if (xfer_idx == 4) begin
        hit = 1;
        break;
      end
    end
    if (!hit) begin
      n_vec++;
      n_err++;
      $display("FAIL reset_setup_timeout: transfers=%0d required=4", xfer_idx);
    end
    #1 rst = 1'b1;
    #1;
    chk("async_rst_re", bus.rx_buff_re, 0);
    chk("async_rst_out", {bus.out_valid, bus.out_sop, bus.out_eop}, 3'b000);
    bus.rx_buff_valid = 1'b0;
    wr_ptr = rd_ptr;
    exp_frames = 0;
    exp_drops = 0;
    repeat (3) @(negedge clk);
    chk("rst_length", bus.out_length, 16'd0);
    check_stats();
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rx_buff_valid  = 1'b0;
    bus.rx_buff_length = 16'd0;
    bus.rx_buff_status = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_re_valid", {bus.rx_buff_re, bus.out_valid, bus.out_sop, bus.out_eop}, 4'b0000);
    chk("rst_be_data", {bus.out_be, bus.out_data}, 36'd0);
    chk("rst_len_status", {bus.out_length, bus.out_status}, 48'd0);
    check_stats();
    rst = 1'b0;
    repeat (3) @(negedge clk);

    send_frame(64,   32'h0, 1'b1, 0, 1'b0);
    send_frame(61,   32'h0, 1'b0, 0, 1'b0);
    send_frame(62,   32'h0, 1'b0, 0, 1'b0);
    send_frame(63,   32'h0, 1'b0, 0, 1'b0);
    send_frame(5,    32'h0, 1'b0, 0, 1'b0);
    send_frame(4,    32'h0, 1'b0, 0, 1'b0);
    send_frame(64,   32'h0, 1'b0, 0, 1'b1);
    send_frame(64,   32'h1, 1'b0, 0, 1'b0);
    check_stats();
    send_frame(0,    32'h0, 1'b0, 0, 1'b0);
    send_frame(1523, 32'h0, 1'b0, 0, 1'b0);
    send_frame(1522, 32'h0, 1'b0, 0, 1'b0);
    send_frame(64,   32'h4, 1'b0, 0, 1'b0);
    send_frame(64,   32'h0, 1'b0, 8, 1'b0);
    check_stats();

    reset_mid();
    send_frame(64,   32'h0, 1'b1, 0, 1'b0);
    check_stats();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aq_gemac_rx_reader.md
AQ_GEMAC_RX_READER -- requirements
Module: aq_gemac_rx_reader

Interface
REQ-001 Parameter DROP_MASK, default 32'h0000_0000: frames with (RX_BUFF_STATUS & DROP_MASK) != 0 are discarded.
REQ-002 Parameter MAX_LEN, default 16'd1522: frames with length > MAX_LEN are discarded.
REQ-003 CLK  in  1  system clock, same clock as the MAC RX buffer read side.
REQ-004 RST  in  1  reset, asynchronous, active-high.
REQ-005 RX_BUFF_RE  out  1  pop one 32-bit word from the RX buffer.
REQ-006 RX_BUFF_DATA  in  32  popped word, valid the cycle after RE; byte 0 in [7:0].
REQ-007 RX_BUFF_EMPTY  in  1  buffer holds no word; RE is never asserted while high.
REQ-008 RX_BUFF_VALID  in  1  a complete frame is available; LENGTH and STATUS are valid.
REQ-009 RX_BUFF_LENGTH  in  16  frame length in bytes.
REQ-010 RX_BUFF_STATUS  in  32  frame status.
REQ-011 OUT_VALID  out  1  output word valid.
REQ-012 OUT_READY  in  1  sink accepts; a transfer occurs when OUT_VALID and OUT_READY are both high.
REQ-013 OUT_DATA  out  32  frame word.
REQ-014 OUT_SOP / OUT_EOP  out  1 each  first / last word of a frame.
REQ-015 OUT_BE  out  4  valid bytes; 4'b1111 except on EOP.
REQ-016 OUT_LENGTH / OUT_STATUS  out  16 / 32  latched frame length and status, stable from SOP through EOP.
REQ-017 FRAME_CNT / DROP_CNT  out  16 each  statistics (see Configuration).

Function
REQ-018 The FSM has four states: IDLE, READ, DRAIN and GAP.
REQ-019 IDLE: if RX_BUFF_VALID=1, the block latches LENGTH and STATUS and computes words = ceil(LENGTH/4), or 1 when LENGTH=0.
REQ-020 IDLE transition: go to DRAIN if LENGTH=0, LENGTH>MAX_LEN, or a STATUS bit matches DROP_MASK; otherwise go to READ.
REQ-021 READ: RE=1 in each cycle where EMPTY=0, words remaining > 0, and the 2-entry output skid buffer has a free slot, counting in-flight pops.
REQ-022 READ: each captured word enters the skid buffer; the first word carries SOP and the last carries EOP.
REQ-023 READ: after the last pop, the FSM goes to GAP.
REQ-024 DRAIN: RE=1 whenever EMPTY=0, until `words` pops are done; OUT_VALID stays 0; the FSM then goes to GAP.
REQ-025 GAP: the FSM stays 2 cycles, then returns to IDLE, letting RX_BUFF_VALID update.
REQ-026 A new frame is not sampled until the previous EOP has transferred.
REQ-027 OUT_BE on EOP, by LENGTH[1:0]: 00->1111, 01->0001, 10->0011, 11->0111.
REQ-028 Latency: if IDLE sees VALID in cycle N, RE is high in N+1 and OUT_VALID/SOP are high in N+3.
REQ-029 Throughput: 1 word/cycle when OUT_READY is held high and EMPTY=0.
REQ-030 OUT_VALID and OUT_DATA/SOP/EOP/BE hold stable while OUT_READY=0; no word is lost or duplicated.
REQ-031 EMPTY=1 mid-frame pauses RE without a state change; popping resumes when EMPTY returns to 0.
REQ-032 OUT_READY low with a full skid buffer: RE=0 within the same cycle.

Reset
REQ-033 While RST=1: FSM=IDLE, skid buffer empty, RX_BUFF_RE=0, OUT_VALID=0, SOP=EOP=0, OUT_BE=0, OUT_DATA=0, OUT_LENGTH=0, OUT_STATUS=0, FRAME_CNT=0, DROP_CNT=0.
REQ-034 Reset mid-frame aborts the frame immediately with no EOP; the RX buffer is reset in the same event by the system.

Configuration
REQ-035 Macro AQ_GEMAC_RX_READER_STATS_EN defined: FRAME_CNT increments on each EOP transfer, and DROP_CNT increments on each DRAIN entry.
REQ-036 Counter width: both counters are 16-bit and saturate at 16'hFFFF.
REQ-037 Macro AQ_GEMAC_RX_READER_STATS_EN undefined: no counter registers exist, and FRAME_CNT=DROP_CNT=0 constantly.

Verification
REQ-038 64-byte frame, READY=1 -> 16 RE pops; 16 transfers with SOP on word 1 and EOP on word 16; BE=1111; OUT_LENGTH=64.
REQ-039 61-byte frame -> 16 transfers, EOP BE=0001.
REQ-040 62-byte frame -> EOP BE=0011.
REQ-041 64-byte frame, READY low for 5 cycles at word 4 -> data held stable; all 16 words delivered in order.
REQ-042 DROP_MASK=1, STATUS=1, 64 bytes -> 16 pops, OUT_VALID never high, DROP_CNT=1 (STATS_EN).
REQ-043 EMPTY pulsed high for 3 cycles at word 8 -> RE low during the pulse; frame delivered intact.
REQ-044 RST asserted at word 5 -> OUT_VALID=0 and RE=0 asynchronously; after RST release, the next 64-byte frame is delivered correctly.
